// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the hazard sequencer.
// The slave side is the sequencer; the master side is the datapath.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             ihit;
    logic             dhit;
    logic             mem_dren;
    logic             mem_dwen;
    logic             mem_redirect;
    logic             mem_halt;
    logic             ex_memread;
    logic [4:0]       ex_rt;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_en;
    logic             id_ex_flush;
    logic             ex_mem_en;
    logic             ex_mem_flush;
    logic             mem_wb_en;
    logic             halt;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;

    modport slave (
        input  ihit, dhit, mem_dren, mem_dwen, mem_redirect, mem_halt,
               ex_memread, ex_rt, id_rs, id_rt,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               ex_mem_en, ex_mem_flush, mem_wb_en, halt, mem_timeout, stall_cycles
    );

    modport master (
        output ihit, dhit, mem_dren, mem_dwen, mem_redirect, mem_halt,
               ex_memread, ex_rt, id_rs, id_rt,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               ex_mem_en, ex_mem_flush, mem_wb_en, halt, mem_timeout, stall_cycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer: turns memory handshakes, load-use, redirect and halt into
// per-latch enable/flush strobes, with data-wait timeout and stall-cycle counters.
module pipeline_hazard_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                   CLK,
    input  logic                   nRST,
    pipeline_hazard_ctrl_if.slave  hz
);
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } state_e;

    localparam int               WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_C = WAIT_W'(TIMEOUT);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              halt_q, halt_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    logic dwait_s, load_use_s;
    logic pc_en_s, if_id_en_s, if_id_flush_s, id_ex_en_s, id_ex_flush_s;
    logic ex_mem_en_s, ex_mem_flush_s, mem_wb_en_s;

    assign dwait_s    = (hz.mem_dren | hz.mem_dwen) & ~hz.dhit;
    assign load_use_s = hz.ex_memread & (hz.ex_rt != 5'd0) &
                        ((hz.ex_rt == hz.id_rs) | (hz.ex_rt == hz.id_rt));

    // Next state and strobe decode; a flushed latch never also sees its enable.
    always_comb begin
        state_d        = state_q;
        pc_en_s        = 1'b0;
        if_id_en_s     = 1'b0;
        if_id_flush_s  = 1'b0;
        id_ex_en_s     = 1'b0;
        id_ex_flush_s  = 1'b0;
        ex_mem_en_s    = 1'b0;
        ex_mem_flush_s = 1'b0;
        mem_wb_en_s    = 1'b0;
        case (state_q)
            HALTED: state_d = HALTED;
            RUN, DWAIT: begin
                if (dwait_s) begin
                    state_d = DWAIT;
                end else begin
                    state_d = hz.mem_halt ? HALTED : RUN;
                    if (hz.mem_redirect) begin
                        pc_en_s        = 1'b1;
                        if_id_flush_s  = 1'b1;
                        id_ex_flush_s  = 1'b1;
                        ex_mem_flush_s = 1'b1;
                        mem_wb_en_s    = 1'b1;
                    end else if (load_use_s) begin
                        id_ex_flush_s  = 1'b1;
                        ex_mem_en_s    = 1'b1;
                        mem_wb_en_s    = 1'b1;
                    end else if (!hz.ihit) begin
                        if_id_flush_s  = 1'b1;
                        id_ex_en_s     = 1'b1;
                        ex_mem_en_s    = 1'b1;
                        mem_wb_en_s    = 1'b1;
                    end else begin
                        pc_en_s        = 1'b1;
                        if_id_en_s     = 1'b1;
                        id_ex_en_s     = 1'b1;
                        ex_mem_en_s    = 1'b1;
                        mem_wb_en_s    = 1'b1;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Wait/timeout and stall counters; the wait count only runs while DWAIT keeps waiting.
    always_comb begin
        wait_cnt_d    = '0;
        halt_d        = halt_q | (state_d == HALTED);
        stall_d       = stall_q;
        if ((state_q == DWAIT) && dwait_s) begin
            if (wait_cnt_q != TIMEOUT_C) begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end else begin
                wait_cnt_d = wait_cnt_q;
            end
        end else begin
            wait_cnt_d = '0;
        end
        mem_timeout_d = mem_timeout_q | ((TIMEOUT != 0) && (wait_cnt_d == TIMEOUT_C));
        if (!pc_en_s && (state_q != HALTED) && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end else begin
            stall_d = stall_q;
        end
    end

    // State and counter registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            halt_q        <= 1'b0;
            mem_timeout_q <= 1'b0;
            stall_q       <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            halt_q        <= halt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_q       <= stall_d;
        end
    end

    assign hz.pc_en        = pc_en_s;
    assign hz.if_id_en     = if_id_en_s;
    assign hz.if_id_flush  = if_id_flush_s;
    assign hz.id_ex_en     = id_ex_en_s;
    assign hz.id_ex_flush  = id_ex_flush_s;
    assign hz.ex_mem_en    = ex_mem_en_s;
    assign hz.ex_mem_flush = ex_mem_flush_s;
    assign hz.mem_wb_en    = mem_wb_en_s;
    assign hz.halt         = halt_q;
    assign hz.mem_timeout  = mem_timeout_q;
    assign hz.stall_cycles = stall_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: a driver pushes reference-model expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_pipeline_hazard_ctrl;
    localparam int CNT_W = 32;
    localparam int TMO   = 4;
    localparam longint STALL_MAX = (64'd1 << CNT_W) - 64'd1;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();
    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
        .CLK (CLK),
        .nRST(nRST),
        .hz  (hz)
    );

    typedef struct packed {
        logic [7:0]       strb;
        logic             halt;
        logic             tmo;
        logic [CNT_W-1:0] stall;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model state: processor halted, waiting on data, wait cycles, sticky timeout, stalls.
    bit     m_halted, m_waiting, m_tmo;
    int     m_wait;
    longint m_stall;

    // Strobe order: pc, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush, mem_wb_en
    function automatic logic [7:0] model_strb(bit halted, bit ih, bit dh, bit dr, bit dw, bit rd,
                                              bit em, logic [4:0] ert, logic [4:0] irs, logic [4:0] irt);
        bit lu;
        lu = em && (ert != 5'd0) && (ert == irs || ert == irt);
        if (halted)                 return 8'b0000_0000;
        if ((dr || dw) && !dh)      return 8'b0000_0000;
        if (rd)                     return 8'b1010_1011;
        if (lu)                     return 8'b0000_1101;
        if (!ih)                    return 8'b0011_0101;
        return 8'b1101_0101;
    endfunction

    task automatic apply(input bit rstn, input bit ih, input bit dh, input bit dr, input bit dw,
                         input bit rd, input bit mh, input bit em,
                         input logic [4:0] ert, input logic [4:0] irs, input logic [4:0] irt);
        exp_t e;
        bit   wait_now;
        hz.ihit = ih; hz.dhit = dh; hz.mem_dren = dr; hz.mem_dwen = dw;
        hz.mem_redirect = rd; hz.mem_halt = mh; hz.ex_memread = em;
        hz.ex_rt = ert; hz.id_rs = irs; hz.id_rt = irt;
        nRST = rstn;
        if (!rstn) begin
            m_halted = 1'b0; m_waiting = 1'b0; m_tmo = 1'b0; m_wait = 0; m_stall = 0;
        end
        e.strb  = model_strb(m_halted, ih, dh, dr, dw, rd, em, ert, irs, irt);
        e.halt  = m_halted;
        e.tmo   = m_tmo;
        e.stall = m_stall[CNT_W-1:0];
        sb_q.push_back(e);
        if (rstn) begin
            wait_now = !m_halted && (dr || dw) && !dh;
            if (!m_halted && !e.strb[7] && m_stall < STALL_MAX) m_stall++;
            if (m_waiting && wait_now) begin
                m_wait++;
                if (TMO != 0 && m_wait == TMO) m_tmo = 1'b1;
            end else begin
                m_wait = 0;
            end
            if (!m_halted && !wait_now && mh) m_halted = 1'b1;
            m_waiting = wait_now;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: every negedge the DUT presents a full output set for the current cycle.
    always @(negedge CLK) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("strobes", 64'({hz.pc_en, hz.if_id_en, hz.if_id_flush, hz.id_ex_en, hz.id_ex_flush,
                                hz.ex_mem_en, hz.ex_mem_flush, hz.mem_wb_en}), 64'(e.strb));
            chk("halt", 64'(hz.halt), 64'(e.halt));
            chk("mem_timeout", 64'(hz.mem_timeout), 64'(e.tmo));
            chk("stall_cycles", 64'(hz.stall_cycles), 64'(e.stall));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        nRST = 1'b0;
        hz.ihit = 1'b0; hz.dhit = 1'b0; hz.mem_dren = 1'b0; hz.mem_dwen = 1'b0;
        hz.mem_redirect = 1'b0; hz.mem_halt = 1'b0; hz.ex_memread = 1'b0;
        hz.ex_rt = 5'd0; hz.id_rs = 5'd0; hz.id_rt = 5'd0;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 2; i++) apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 10; i++) apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        // Load-use, then the same with ex_rt of zero.
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0);
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
        // Data read waiting three cycles, then completing.
        for (int i = 0; i < 3; i++) apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        // Redirect during a fetch miss.
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        // Write wait coinciding with load-use.
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7);
        apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7);
        // Long wait past the timeout, then recovery with the flag staying set.
        for (int i = 0; i < 6; i++) apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 3; i++) apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        // Halt, a few halted cycles, then asynchronous reset and restart.
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 3; i++) apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        // Randomized traffic with occasional halts and resets.
        for (int i = 0; i < 800; i++) begin
            apply($urandom_range(0, 79) != 0,
                  $urandom_range(0, 9) < 8,
                  $urandom_range(0, 9) < 4,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 6) == 0,
                  $urandom_range(0, 6) == 0,
                  $urandom_range(0, 59) == 0,
                  $urandom_range(0, 9) < 4,
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)));
        end
        @(negedge CLK);
        #1;
        n_vec++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
